// File: rtl/div_unit.sv
// Radix-2 restoring integer divider, one quotient bit per cycle.
// Handles signed/unsigned operands, cancel, and defined divide-by-zero results.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             res_dbz_q, res_dbz_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_dbz_q, out_dbz_d;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             fits;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_dbz_q <= 1'b0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      out_dbz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      res_dbz_q <= res_dbz_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      out_dbz_q <= out_dbz_d;
    end
  end

  assign accept = start && !cancel;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (opdata2 == '0) ? DONE : CALC;
      CALC: begin
        if (cancel)              state_d = IDLE;
        else if (cnt_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abs_a    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs_b    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    // Shift in the next dividend bit, subtract the divisor only when it fits.
    shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, dvsr_q});
    rem_next = fits ? (shifted - {1'b0, dvsr_q}) : shifted;
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_dbz_d = res_dbz_q;
    out_quo_d = out_quo_q;
    out_rem_d = out_rem_q;
    out_dbz_d = out_dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = abs_a;
          dvsr_d    = abs_b;
          neg_quo_d = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          neg_rem_d = signed_div && opdata1[WIDTH-1];
          if (opdata2 == '0) begin
            res_quo_d = '1;
            res_rem_d = opdata1;
            res_dbz_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (!cancel) begin
          cnt_d = cnt_q + CW'(1);
          rem_d = rem_next;
          quo_d = quo_next;
          if (cnt_q == LAST) begin
            res_quo_d = neg_quo_q ? -quo_next : quo_next;
            res_rem_d = neg_rem_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
            res_dbz_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (!cancel) begin
          out_quo_d = res_quo_q;
          out_rem_d = res_rem_q;
          out_dbz_d = res_dbz_q;
        end
      end
      default: ;
    endcase
  end

  // Fresh results are presented during the ready cycle; otherwise the last
  // committed results are held.
  always_comb begin
    busy        = (state_q != IDLE);
    ready       = (state_q == DONE) && !cancel;
    quotient    = ready ? res_quo_q : out_quo_q;
    remainder   = ready ? res_rem_q : out_rem_q;
    div_by_zero = ready ? res_dbz_q : out_dbz_q;
  end

endmodule
